// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory access sequencer.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int MEM_WIDTH  = 8;
    localparam int MEM_ROWS   = 8;
    localparam int MEM_ADDR_W = 3;
    localparam int MEM_SETTLE = 2;

    // The settle counter only has to reach SETTLE-1, so SETTLE+1 states is plenty.
    function automatic int cnt_width(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus memory array word-line and bitline signals.
interface mem_access_ctrl_if
    import mem_pkg::*;
#(
    parameter int WIDTH  = MEM_WIDTH,
    parameter int ROWS   = MEM_ROWS,
    parameter int ADDR_W = MEM_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic [ROWS-1:0]   row_sel;
    logic              wr_en;
    logic [WIDTH-1:0]  wdata_out;
    logic [WIDTH-1:0]  rdata_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;

    // Requester and memory array side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata_in,
        input  req_ready, row_sel, wr_en, wdata_out, rsp_valid, rsp_rdata, rsp_err
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata_in,
        output req_ready, row_sel, wr_en, wdata_out, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/row_decoder.sv
// Word address to one-hot row select; all-zero when disabled or out of range.
module row_decoder #(
    parameter int ROWS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [ROWS-1:0]   sel
);

    // NOTE: default every always_comb output first so no latch is inferred.
    always_comb begin
        sel = '0;
        // Only rows 0..ROWS-1 exist, so an address >= ROWS matches nothing.
        for (int i = 0; i < ROWS; i++) begin
            sel[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding sequencer: decode, hold the row for SETTLE cycles, then respond.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH  = MEM_WIDTH,
    parameter int ROWS   = MEM_ROWS,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int SETTLE = MEM_SETTLE
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(SETTLE);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             write_q;
    logic             err_q;
    logic             accept;
    logic             last_access;
    logic             rsp_done;
    logic             addr_err;
    logic [ROWS-1:0]  dec_sel;

    assign addr_err      = 32'(bus.req_addr) >= 32'(ROWS);
    assign bus.req_ready = (state == IDLE) && rst_n;

    row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .addr (bus.req_addr),
        .en   (accept),
        .sel  (dec_sel)
    );

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        last_access = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    last_access = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            bus.row_sel   <= '0;
            bus.wr_en     <= 1'b0;
            bus.wdata_out <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (accept) begin
            cnt           <= '0;
            write_q       <= bus.req_write;
            err_q         <= addr_err;
            bus.row_sel   <= dec_sel;
            bus.wr_en     <= bus.req_write && !addr_err;
            bus.wdata_out <= bus.req_wdata;
        end else if (last_access) begin
            // Dropping the row here gives the break-before-make gap through RESP.
            bus.row_sel   <= '0;
            bus.wr_en     <= 1'b0;
            bus.wdata_out <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= (write_q || err_q) ? '0 : bus.rdata_in;
            bus.rsp_err   <= err_q;
        end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
        end else if (rsp_done) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: driver predicts responses from a word-array model, monitor checks every cycle.
module tb_mem_access_ctrl;

    localparam int WIDTH  = 8;
    localparam int ROWS   = 6;
    localparam int ADDR_W = 3;
    localparam int SETTLE = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [WIDTH-1:0]  wdata;
        logic [ROWS-1:0]   sel;
        logic              wr;
        logic [WIDTH-1:0]  rdata;
        logic              err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   force_bp  = 1'b0;
    bit   in_flight = 1'b0;
    bit   rst_seen  = 1'b1;
    int   age       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] ref_mem [ROWS];
    logic [WIDTH-1:0] arr     [ROWS];

    mem_access_ctrl_if #(.WIDTH(WIDTH), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus ();

    mem_access_ctrl #(
        .WIDTH  (WIDTH),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] init_val(input int i);
        return (i == 5) ? 8'hA5 : WIDTH'(i * 37 + 11);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name, input int waited);
        n_tests++;
        n_fail++;
        $display("FAIL %s: waited %0d cycles, limit reached at %0t", name, waited, $time);
    endtask

    // Memory array: word lines select rows, read data is the OR of selected rows.
    always_comb begin
        bus.rdata_in = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (bus.row_sel[i]) bus.rdata_in = bus.rdata_in | arr[i];
        end
    end

    initial begin
        for (int i = 0; i < ROWS; i++) arr[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (bus.wr_en) begin
                for (int i = 0; i < ROWS; i++) begin
                    if (bus.row_sel[i]) arr[i] <= bus.wdata_out;
                end
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = force_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares the DUT outputs each cycle against the front of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                check("rst_row_sel",   32'(bus.row_sel),   32'd0);
                check("rst_wr_en",     32'(bus.wr_en),     32'd0);
                check("rst_wdata_out", 32'(bus.wdata_out), 32'd0);
                check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
                check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
                check("rst_req_ready", 32'(bus.req_ready), 32'(rst_n));
            end else begin
                if (in_flight) age++;
                check("req_ready", 32'(bus.req_ready), 32'(rst_n && !in_flight));
                if (!in_flight) begin
                    check("idle_row_sel",   32'(bus.row_sel),   32'd0);
                    check("idle_wr_en",     32'(bus.wr_en),     32'd0);
                    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                end else if (sb_q.size() == 0) begin
                    check("sb_entry_present", 32'(sb_q.size()), 32'd1);
                end else if (age <= SETTLE) begin
                    e = sb_q[0];
                    check("acc_row_sel",   32'(bus.row_sel),   32'(e.sel));
                    check("acc_wr_en",     32'(bus.wr_en),     32'(e.wr));
                    check("acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                    if (e.wr) check("acc_wdata_out", 32'(bus.wdata_out), 32'(e.wdata));
                end else begin
                    e = sb_q[0];
                    check("rsp_row_sel", 32'(bus.row_sel),   32'd0);
                    check("rsp_wr_en",   32'(bus.wr_en),     32'd0);
                    check("rsp_valid",   32'(bus.rsp_valid), 32'd1);
                    check("rsp_rdata",   32'(bus.rsp_rdata), 32'(e.rdata));
                    check("rsp_err",     32'(bus.rsp_err),   32'(e.err));
                end
            end

            if (!rst_n) begin
                rst_seen  = 1'b1;
                in_flight = 1'b0;
                age       = 0;
                sb_q.delete();
            end else begin
                rst_seen = 1'b0;
                if (in_flight && bus.rsp_valid && bus.rsp_ready) begin
                    void'(sb_q.pop_front());
                    in_flight = 1'b0;
                end else if (bus.req_valid && bus.req_ready) begin
                    in_flight = 1'b1;
                    age       = 0;
                end
            end
        end
    end

    // Present a request until accepted, then record what the array must answer.
    task automatic issue(input logic wr, input int addr, input logic [WIDTH-1:0] wd);
        exp_t e;
        int   waited = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_wdata = wd;
        do begin
            @(negedge clk);
            waited++;
        end while (!(bus.req_ready && rst_n) && waited < 100);
        if (!(bus.req_ready && rst_n)) begin
            fail_bound("req_accept_timeout", waited);
            bus.req_valid = 1'b0;
            return;
        end
        e.addr  = ADDR_W'(addr);
        e.write = wr;
        e.wdata = wd;
        e.err   = (addr >= ROWS);
        e.sel   = e.err ? '0 : ROWS'(1) << addr;
        e.wr    = wr && !e.err;
        e.rdata = (wr || e.err) ? '0 : ref_mem[addr];
        if (e.wr) ref_mem[addr] = wd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = ADDR_W'($urandom_range(0, 7));
        bus.req_wdata = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) fail_bound("rsp_timeout", n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) ref_mem[i] = init_val(i);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(5);
        bus.req_wdata = '0;

        // Reset held two cycles with a request pending.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(1'b0, 5, 8'h00);
        issue(1'b1, 0, 8'h3C);
        issue(1'b0, 0, 8'h00);
        wait_idle();

        // Back-pressure: response held for several cycles.
        force_bp = 1'b1;
        issue(1'b0, 3, 8'h00);
        repeat (SETTLE + 6) @(posedge clk);
        #1;
        force_bp = 1'b0;
        wait_idle();

        // Out-of-range addresses, including the first one past the last row.
        issue(1'b0, 7, 8'h00);
        issue(1'b1, 6, 8'h5A);
        issue(1'b0, 6, 8'h00);
        issue(1'b0, ROWS - 1, 8'h00);
        wait_idle();

        // Reset during cycle 1 of a write; same data so the array stays consistent.
        issue(1'b1, 2, ref_mem[2]);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 2, 8'h00);
        wait_idle();

        for (int k = 0; k < 60; k++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), WIDTH'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
